// File: rtl/mult_seq_ctrl.sv
// Radix-4 iterative unsigned multiplier controller with valid/ready on both sides.
// Optional early termination on exhausted multiplier bits: MULT_SEQ_EARLY_TERM_EN.
module mult_seq_ctrl #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH/2) + 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] product,
    output logic               busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH/2 - 1);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [WIDTH-1:0]     r_a;
    logic [WIDTH-1:0]     r_b;
    logic [2*WIDTH-1:0]   r_acc;
    logic [CNT_W-1:0]     r_cnt;

    logic                 w_accept;
    logic                 w_last;
    logic                 w_skip;
    logic [WIDTH-1:0]     w_b_nxt;
    logic [2*WIDTH-1:0]   w_pp0;
    logic [2*WIDTH-1:0]   w_pp1;
    logic [2*WIDTH-1:0]   w_pp;
    logic [2*WIDTH-1:0]   w_add;

    // One radix-4 digit: the two partial-product rows share a single adder
    assign w_pp0   = r_b[0] ? {{WIDTH{1'b0}}, r_a} : '0;
    assign w_pp1   = r_b[1] ? {{(WIDTH-1){1'b0}}, r_a, 1'b0} : '0;
    assign w_pp    = w_pp0 + w_pp1;
    assign w_add   = w_pp << {r_cnt, 1'b0};
    assign w_b_nxt = r_b >> 2;

`ifdef MULT_SEQ_EARLY_TERM_EN
    assign w_last = (w_b_nxt == '0);
    assign w_skip = (b == '0);
`else
    assign w_last = (r_cnt == LAST_CNT);
    assign w_skip = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = w_skip ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a   <= '0;
            r_b   <= '0;
            r_acc <= '0;
            r_cnt <= '0;
        end else if (w_accept) begin
            r_a   <= a;
            r_b   <= b;
            r_acc <= '0;
            r_cnt <= '0;
        end else if (r_state == S_RUN) begin
            r_acc <= r_acc + w_add;
            r_b   <= w_b_nxt;
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign product = r_acc;
    assign busy    = (r_state != S_IDLE);

endmodule
